alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Takes operands x, y and a 3-bit opcode through a valid/ready input handshake, and returns a registered result plus status flags through a valid/ready output handshake.
- Single-cycle ops return in 1 cycle. MUL runs an iterative shift-add over WIDTH cycles.
- Sits between an operand source (sequencer or register file) and a result sink that can apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- op  input  3  opcode; replaces the {s2,s1,s0} select, same encoding for 000-101.
- out_valid  output  1  result held on z/flags.
- out_ready  input  1  sink accepts result this cycle.
- z  output  WIDTH  result.
- carry  output  1  ADD carry-out / SUB borrow.
- zero  output  1  z == 0.
- ovf  output  1  signed overflow (ADD/SUB) or unsigned product overflow (MUL).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Opcodes:
  - 000 AND: x&y.
  - 001 OR: x|y.
  - 010 NOT: ~x (y ignored).
  - 011 XOR: x^y.
  - 100 ADD: x+y mod 2^WIDTH.
  - 101 SUB: x-y mod 2^WIDTH.
  - 110 MUL: low WIDTH bits of unsigned x*y.
  - 111 LTU: z = {0..0, (x<y unsigned)}.
- Flags:
  - zero: set for every op.
  - carry: ADD carry-out; SUB =1 when x<y unsigned; 0 for all other ops.
  - ovf:
    - ADD/SUB: signed two's-complement overflow.
    - MUL: =1 when upper WIDTH bits of the 2*WIDTH product are nonzero.
    - All other ops: 0.
- FSM states: IDLE (no result held), BUSY (MUL iterating), HOLD (result valid).
- Handshake outputs:
  - in_ready = (state==IDLE) | (state==HOLD & out_ready); forced 0 in BUSY.
  - out_valid = (state==HOLD).
- Accept: a beat is accepted on a rising edge where in_valid & in_ready. x, y and op are captured only at acceptance; later input changes are ignored.
- Non-MUL op accepted: result and flags registered on the same edge. Next state HOLD, so latency is 1 cycle.
- MUL accepted:
  - Latch multiplicand (x) and multiplier (y), clear a 2*WIDTH accumulator, load counter = WIDTH. Next state BUSY.
  - Each BUSY cycle: if multiplier LSB is set, add the shifted multiplicand into the accumulator; shift multiplicand left and multiplier right; decrement the counter.
  - When the counter reaches 0, register z/flags and go to HOLD.
  - out_valid rises exactly WIDTH cycles after the accept edge (8 for WIDTH=8).
- HOLD:
  - z and flags stay stable while out_ready=0.
  - On out_ready=1 the result is consumed. If no new beat is accepted on that same edge, go to IDLE. If a new beat is accepted (back-to-back), go to HOLD (non-MUL) or BUSY (MUL) with no bubble.
- Reset, including mid-MUL:
  - state=IDLE, z=0, carry=0, zero=0, ovf=0, out_valid=0.
  - in_ready=1 from the first edge after reset deasserts.
  - Any partial product is discarded.
- in_valid asserted in BUSY: beat not accepted; the source must hold it until in_ready.
- Flags are only meaningful while out_valid=1. They hold their last values otherwise and are never cleared except by reset.

Test Plan:
- WIDTH=8, x=0xAA, y=0xCC, ops 000..011 issued back-to-back with out_ready=1:
  - Outputs z=0x88, 0xEE, 0x55, 0x66, one result per cycle, each 1 cycle after accept.
  - in_ready stays 1 throughout.
- ADD 0xAA+0xCC -> z=0x76, carry=1, ovf=1, zero=0.
- SUB 0xAA-0xCC -> z=0xDE, carry=1, ovf=0.
- SUB 0x05-0x05 -> z=0x00, zero=1, carry=0.
- MUL cases:
  - 0x0F*0x11 -> z=0xFF, ovf=0. out_valid rises 8 cycles after accept; in_ready=0 throughout BUSY.
  - 0x10*0x10 -> z=0x00, zero=1, ovf=1.
- Backpressure: LTU 0x03,0x05 with out_ready=0 for 5 cycles.
  - z=0x01 stable, out_valid=1, in_ready=0 during the stall.
  - Raise out_ready together with a new ADD beat: handed over with no bubble.
- Reset and WIDTH sweep:
  - Assert rst 3 cycles into a MUL: out_valid=0, z=0 immediately (async).
  - After release, in_ready=1 and a new AND executes correctly.
  - Repeat the ADD/SUB/MUL checks with WIDTH=16: 0xFFFF+0x0001 -> z=0x0000, carry=1, zero=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on input and output.
// Single-cycle ops (AND/OR/NOT/XOR/ADD/SUB/LTU) return one cycle after accept.
// MUL is an iterative shift-add taking WIDTH cycles.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand beat handshake (x, y, op)
//   out_valid/ out_ready result handshake (z, carry, zero, ovf)
module alu_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_LTU = 3'b111;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic [PW-1:0]    acc_step;
   logic [WIDTH-1:0] alu_z;
   logic             alu_c;
   logic             alu_v;

   // Handshake decode; in_ready is held low while reset is asserted.
   assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid & in_ready;

   assign z     = z_q;
   assign carry = carry_q;
   assign zero  = zero_q;
   assign ovf   = ovf_q;

   assign sum      = {1'b0, x} + {1'b0, y};
   assign diff     = x - y;
   assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

   // Single-cycle result and flags from the live operands.
   always_comb begin
      alu_z = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (op)
         OP_AND: alu_z = x & y;
         OP_OR:  alu_z = x | y;
         OP_NOT: alu_z = ~x;
         OP_XOR: alu_z = x ^ y;
         OP_ADD: begin
            alu_z = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = ~(x[WIDTH-1] ^ y[WIDTH-1]) & (sum[WIDTH-1] ^ x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_z = diff;
            alu_c = (x < y);
            alu_v = (x[WIDTH-1] ^ y[WIDTH-1]) & (diff[WIDTH-1] ^ x[WIDTH-1]);
         end
         OP_LTU: alu_z = WIDTH'(x < y);
         default: alu_z = '0;
      endcase
   end

   // Next-state: MUL iteration, result consumption, and beat acceptance.
   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: ;
         BUSY: begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            // Last iteration: publish the product on this same edge.
            if (cnt_q == CW'(1)) begin
               z_d     = acc_step[WIDTH-1:0];
               zero_d  = (acc_step[WIDTH-1:0] == '0);
               carry_d = 1'b0;
               ovf_d   = |acc_step[PW-1:WIDTH];
               state_d = HOLD;
            end
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // accept can only be true in IDLE or in HOLD while the result is consumed.
      if (accept) begin
         if (op == OP_MUL) begin
            mcand_d = PW'(x);
            mplr_d  = y;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
         end else begin
            z_d     = alu_z;
            zero_d  = (alu_z == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            state_d = HOLD;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         z_q     <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       iv, ir, ov, ordy, c, zr, vf;
   logic [7:0] xa, ya, za;
   logic [2:0] opa;

   // WIDTH=16 instance
   logic        iv2, ir2, ov2, ordy2, c2, zr2, vf2;
   logic [15:0] xb, yb, zb;
   logic [2:0]  opb;

   int total = 0;
   int bad   = 0;
   int n;

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .x(xa), .y(ya), .op(opa),
      .out_valid(ov), .out_ready(ordy), .z(za), .carry(c), .zero(zr), .ovf(vf)
   );

   alu_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .x(xb), .y(yb), .op(opb),
      .out_valid(ov2), .out_ready(ordy2), .z(zb), .carry(c2), .zero(zr2), .ovf(vf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat, let it be accepted on the next edge, then drop in_valid.
   task automatic beat8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      iv = 1'b1; opa = o; xa = a; ya = b;
      @(posedge clk); #1;
      iv = 1'b0;
   endtask

   task automatic beat16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      iv2 = 1'b1; opb = o; xb = a; yb = b;
      @(posedge clk); #1;
      iv2 = 1'b0;
   endtask

   logic [7:0] logic_exp [4];

   initial begin
      logic_exp[0] = 8'h88; logic_exp[1] = 8'hEE; logic_exp[2] = 8'h55; logic_exp[3] = 8'h66;
      iv = 1'b0; ordy = 1'b1; xa = '0; ya = '0; opa = '0;
      iv2 = 1'b0; ordy2 = 1'b1; xb = '0; yb = '0; opb = '0;

      // Reset state
      #1;
      chk("rst_out_valid", 32'(ov), 32'd0);
      chk("rst_z", 32'(za), 32'd0);
      chk("rst_flags", 32'({c, zr, vf}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(ir), 32'd1);

      // Logic ops back-to-back, one result per cycle
      for (int i = 0; i < 4; i++) begin
         iv = 1'b1; opa = 3'(i); xa = 8'hAA; ya = 8'hCC;
         chk($sformatf("logic%0d_in_ready", i), 32'(ir), 32'd1);
         @(posedge clk); #1;
         chk($sformatf("logic%0d_out_valid", i), 32'(ov), 32'd1);
         chk($sformatf("logic%0d_z", i), 32'(za), 32'(logic_exp[i]));
      end
      iv = 1'b0;
      @(posedge clk); #1;
      chk("logic_drain_out_valid", 32'(ov), 32'd0);

      // ADD / SUB
      beat8(3'b100, 8'hAA, 8'hCC);
      chk("add_z", 32'(za), 32'h76);
      chk("add_flags_c_z_v", 32'({c, zr, vf}), 32'b101);
      beat8(3'b101, 8'hAA, 8'hCC);
      chk("sub_z", 32'(za), 32'hDE);
      chk("sub_flags_c_z_v", 32'({c, zr, vf}), 32'b100);
      beat8(3'b101, 8'h05, 8'h05);
      chk("sub_eq_z", 32'(za), 32'h00);
      chk("sub_eq_flags_c_z_v", 32'({c, zr, vf}), 32'b010);

      // MUL 0x0F*0x11: BUSY for 8 cycles, operands changed after accept
      beat8(3'b110, 8'h0F, 8'h11);
      xa = 8'h00; ya = 8'h00;
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("mul_busy%0d_in_ready", k), 32'(ir), 32'd0);
         chk($sformatf("mul_busy%0d_out_valid", k), 32'(ov), 32'd0);
         @(posedge clk); #1;
      end
      chk("mul_last_busy_out_valid", 32'(ov), 32'd0);
      @(posedge clk); #1;
      chk("mul1_out_valid", 32'(ov), 32'd1);
      chk("mul1_z", 32'(za), 32'hFF);
      chk("mul1_flags_c_z_v", 32'({c, zr, vf}), 32'b000);

      // MUL 0x10*0x10 back-to-back with the previous result
      beat8(3'b110, 8'h10, 8'h10);
      n = 0;
      while (!ov && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mul2_latency", 32'(n), 32'd8);
      chk("mul2_z", 32'(za), 32'h00);
      chk("mul2_flags_c_z_v", 32'({c, zr, vf}), 32'b011);

      // Backpressure: LTU held for 5 cycles while an ADD beat waits
      beat8(3'b111, 8'h03, 8'h05);
      ordy = 1'b0;
      iv = 1'b1; opa = 3'b100; xa = 8'h10; ya = 8'h20;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d_z", k), 32'(za), 32'h01);
         chk($sformatf("stall%0d_out_valid", k), 32'(ov), 32'd1);
         chk($sformatf("stall%0d_in_ready", k), 32'(ir), 32'd0);
         @(posedge clk); #1;
      end
      ordy = 1'b1;
      #1;
      chk("release_in_ready", 32'(ir), 32'd1);
      @(posedge clk); #1;
      iv = 1'b0;
      chk("handover_out_valid", 32'(ov), 32'd1);
      chk("handover_z", 32'(za), 32'h30);
      chk("handover_flags_c_z_v", 32'({c, zr, vf}), 32'b000);

      // WIDTH=16 checks
      beat16(3'b100, 16'hFFFF, 16'h0001);
      chk("w16_add_z", 32'(zb), 32'h0000);
      chk("w16_add_flags_c_z_v", 32'({c2, zr2, vf2}), 32'b110);
      beat16(3'b101, 16'h8000, 16'h0001);
      chk("w16_sub_z", 32'(zb), 32'h7FFF);
      chk("w16_sub_flags_c_z_v", 32'({c2, zr2, vf2}), 32'b001);
      beat16(3'b101, 16'h0000, 16'h0001);
      chk("w16_sub_borrow_z", 32'(zb), 32'hFFFF);
      chk("w16_sub_borrow_flags_c_z_v", 32'({c2, zr2, vf2}), 32'b100);
      beat16(3'b110, 16'h00FF, 16'h0101);
      n = 0;
      while (!ov2 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w16_mul1_latency", 32'(n), 32'd16);
      chk("w16_mul1_z", 32'(zb), 32'hFFFF);
      chk("w16_mul1_flags_c_z_v", 32'({c2, zr2, vf2}), 32'b000);
      beat16(3'b110, 16'h0100, 16'h0100);
      n = 0;
      while (!ov2 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("w16_mul2_latency", 32'(n), 32'd16);
      chk("w16_mul2_z", 32'(zb), 32'h0000);
      chk("w16_mul2_flags_c_z_v", 32'({c2, zr2, vf2}), 32'b011);

      // Reset in the middle of a MUL
      beat8(3'b110, 8'h0F, 8'h11);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midmul_rst_out_valid", 32'(ov), 32'd0);
      chk("midmul_rst_z", 32'(za), 32'd0);
      chk("midmul_rst_flags", 32'({c, zr, vf}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midmul_post_in_ready", 32'(ir), 32'd1);
      chk("midmul_post_out_valid", 32'(ov), 32'd0);
      beat8(3'b000, 8'h5A, 8'h0F);
      chk("post_rst_and_z", 32'(za), 32'h0A);
      chk("post_rst_and_out_valid", 32'(ov), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      chk("no_stale_mul_out_valid", 32'(ov), 32'd0);
      chk("no_stale_mul_z", 32'(za), 32'h0A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
